// File: rtl/adder_pipe_n.sv
// adder_pipe_n : pipelined N-bit add/subtract unit with valid/ready flow control.
//
// The carry chain is split into STAGES chunks of CW = N/STAGES bits. Stage k
// adds chunk k plus the carry registered by stage k-1, so each chunk's carry
// reaches the next chunk with exactly one cycle of skew. All stages share one
// enable (en = ~o_valid | o_ready); when the output is stalled every stage holds.
//
// Optional build macro: ADDER_PIPE_SATURATE_EN
//   defined   : on signed overflow the result is clamped to the signed extreme
//               (sign taken from a[N-1]); c_out/overflow still report raw values.
//   undefined : the result is always the wrapped raw sum.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   i_valid  in   operands valid
//   i_ready  out  unit accepts operands this cycle
//   a, b     in   N-bit operands
//   c_in     in   carry-in (add) / borrow-in (subtract)
//   sub      in   0: a+b+c_in, 1: a-b-c_in
//   o_valid  out  result valid
//   o_ready  in   downstream accepts result
//   sum      out  N-bit result
//   c_out    out  carry out of MSB (subtract: 1 = no borrow)
//   overflow out  signed overflow

module adder_pipe_n #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow
);

  localparam int CW = N / STAGES;

  logic         en;
  logic [N-1:0] b_eff;
  logic         cin_eff;

  assign en      = ~o_valid | o_ready;
  assign i_ready = en;

  // Subtraction as a + ~b + ~borrow_in.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? ~c_in : c_in;

  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    // RW: operand bits not yet consumed (current chunk at the bottom).
    // SW: sum bits completed once this stage has added its chunk.
    localparam int RW = N - k * CW;
    localparam int SW = (k + 1) * CW;

    logic [RW-1:0] a_in;
    logic [RW-1:0] b_in;
    logic          cy_in;
    logic          v_in;
    logic [CW:0]   chunk;
    logic [SW-1:0] s_new;

    assign chunk = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, cy_in};

    if (k == 0) begin : g_src
      assign a_in  = a;
      assign b_in  = b_eff;
      assign cy_in = cin_eff;
      assign v_in  = i_valid;
      assign s_new = chunk[CW-1:0];
    end else begin : g_src
      assign a_in  = gen_stage[k-1].g_mid.a_q;
      assign b_in  = gen_stage[k-1].g_mid.b_q;
      assign cy_in = gen_stage[k-1].g_mid.c_q;
      assign v_in  = gen_stage[k-1].g_mid.v_q;
      assign s_new = {chunk[CW-1:0], gen_stage[k-1].g_mid.s_q};
    end

    if (k < STAGES - 1) begin : g_mid
      logic [RW-CW-1:0] a_q, a_d;
      logic [RW-CW-1:0] b_q, b_d;
      logic [SW-1:0]    s_q, s_d;
      logic             c_q, c_d;
      logic             v_q, v_d;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        s_d = s_q;
        c_d = c_q;
        v_d = v_q;
        if (en) begin
          a_d = a_in[RW-1:CW];
          b_d = b_in[RW-1:CW];
          s_d = s_new;
          c_d = chunk[CW];
          v_d = v_in;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
          s_q <= s_d;
          c_q <= c_d;
          v_q <= v_d;
        end
      end
    end else begin : g_last
      logic [N-1:0] sum_q, sum_d;
      logic [N-1:0] sum_res;
      logic         c_out_q, c_out_d;
      logic         ovf_q, ovf_d;
      logic         ovf_raw;
      logic         v_q, v_d;

      // Carry into the MSB is a^b^sum at that bit; overflow is it XOR carry-out.
      assign ovf_raw = a_in[CW-1] ^ b_in[CW-1] ^ chunk[CW-1] ^ chunk[CW];

`ifdef ADDER_PIPE_SATURATE_EN
      assign sum_res = !ovf_raw     ? s_new :
                       a_in[CW-1]   ? {1'b1, {(N-1){1'b0}}} :
                                      {1'b0, {(N-1){1'b1}}};
`else
      assign sum_res = s_new;
`endif

      always_comb begin
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        v_d     = v_q;
        if (en) begin
          sum_d   = sum_res;
          c_out_d = chunk[CW];
          ovf_d   = ovf_raw;
          v_d     = v_in;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sum_q   <= '0;
          c_out_q <= 1'b0;
          ovf_q   <= 1'b0;
          v_q     <= 1'b0;
        end else begin
          sum_q   <= sum_d;
          c_out_q <= c_out_d;
          ovf_q   <= ovf_d;
          v_q     <= v_d;
        end
      end
    end
  end

  assign o_valid  = gen_stage[STAGES-1].g_last.v_q;
  assign sum      = gen_stage[STAGES-1].g_last.sum_q;
  assign c_out    = gen_stage[STAGES-1].g_last.c_out_q;
  assign overflow = gen_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_adder_pipe_n.sv
module tb_adder_pipe_n;

  logic       clk;
  logic       rst;
  logic       i_valid, i_ready, o_valid, o_ready;
  logic [7:0] a, b, sum;
  logic       c_in, sub, c_out, overflow;

  logic        i_valid1, i_ready1, o_valid1, o_ready1;
  logic [15:0] a1, b1, sum1;
  logic        c_in1, sub1, c_out1, overflow1;

  int passed = 0;
  int total  = 0;

  adder_pipe_n #(.N(8), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .o_valid(o_valid), .o_ready(o_ready),
    .sum(sum), .c_out(c_out), .overflow(overflow)
  );

  adder_pipe_n #(.N(16), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .i_valid(i_valid1), .i_ready(i_ready1),
    .a(a1), .b(b1), .c_in(c_in1), .sub(sub1),
    .o_valid(o_valid1), .o_ready(o_ready1),
    .sum(sum1), .c_out(c_out1), .overflow(overflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
  endtask

  // Reference: {overflow, c_out, sum} from plain 9-bit arithmetic.
  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic mci, input logic msu);
    logic [7:0] be;
    logic [8:0] full;
    logic [7:0] s;
    logic       ov;
    be   = msu ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, be} + {8'd0, (msu ? ~mci : mci)};
    s    = full[7:0];
    ov   = (ma[7] == be[7]) && (s[7] != ma[7]);
`ifdef ADDER_PIPE_SATURATE_EN
    if (ov) s = ma[7] ? 8'h80 : 8'h7F;
`endif
    return {ov, full[8], s};
  endfunction

  typedef struct {
    logic [7:0] va, vb;
    logic       vci, vsu;
    logic [7:0] esum;
    logic       ecout, eovf;
  } vec_t;

  vec_t vecs[10];

  // Issue one op on the 8-bit unit; returns edges from acceptance to o_valid.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tci,
                       input logic tsu, output int lat);
    int n;
    @(negedge clk);
    a = ta; b = tb_; c_in = tci; sub = tsu; i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = n;
  endtask

  initial begin
    int lat;
    int sent, rcvd;
    logic [9:0] q[$];
    logic [9:0] exp_r, held;
    logic [7:0] sa[10], sb[10];
    logic       sc[10], ss[10];

    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    i_valid1 = 1'b0; o_ready1 = 1'b1; a1 = '0; b1 = '0; c_in1 = 1'b0; sub1 = 1'b0;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
`ifdef ADDER_PIPE_SATURATE_EN
    vecs[2] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'hFF, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1};
`else
    vecs[2] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1};
`endif
    vecs[5] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0};
    vecs[6] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0};
    vecs[7] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[8] = '{8'h55, 8'hAB, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[9] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_o_valid", 32'(o_valid), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_c_out", 32'(c_out), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_i_ready", 32'(i_ready), 32'd1);
    rst = 1'b0;

    // Directed vectors, one at a time
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vci, vecs[i].vsu, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].esum));
      chk($sformatf("vec%0d_c_out", i), 32'(c_out), 32'(vecs[i].ecout));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].eovf));
    end
    @(negedge clk);

    // Stream with a stall on cycles 6-8
    for (int i = 0; i < 10; i++) begin
      sa[i] = 8'($urandom); sb[i] = 8'($urandom);
      sc[i] = 1'($urandom); ss[i] = 1'($urandom);
    end
    sent = 0; rcvd = 0; held = '0;
    for (int c = 0; c < 60 && rcvd < 10; c++) begin
      @(negedge clk);
      o_ready = !(c >= 6 && c <= 8);
      if (sent < 10) begin
        i_valid = 1'b1; a = sa[sent]; b = sb[sent]; c_in = sc[sent]; sub = ss[sent];
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (c >= 6 && c <= 8) begin
        chk("stall_i_ready", 32'(i_ready), 32'd0);
        chk("stall_o_valid", 32'(o_valid), 32'd1);
        if (c == 6) held = {overflow, c_out, sum};
        else chk("stall_hold", 32'({overflow, c_out, sum}), 32'(held));
      end
      if (o_valid && o_ready) begin
        if (q.size() == 0) begin
          chk("stream_extra_result", 32'd1, 32'd0);
        end else begin
          exp_r = q.pop_front();
          chk($sformatf("stream_res%0d", rcvd), 32'({overflow, c_out, sum}), 32'(exp_r));
        end
        rcvd++;
      end
      if (i_valid && i_ready) begin
        q.push_back(model(a, b, c_in, sub));
        sent++;
      end
    end
    chk("stream_count", 32'(rcvd), 32'd10);
    chk("stream_sent", 32'(sent), 32'd10);
    i_valid = 1'b0;
    o_ready = 1'b1;

    // Reset with three ops in flight
    @(negedge clk);
    a = 8'h11; b = 8'h22; c_in = 1'b0; sub = 1'b0; i_valid = 1'b1;
    @(posedge clk); #1 a = 8'h33;
    @(posedge clk); #1 a = 8'h44;
    @(posedge clk); #1;
    rst = 1'b1; o_ready = 1'b0; i_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; o_ready = 1'b1; i_valid = 1'b0;
    chk("midrst_o_valid", 32'(o_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_i_ready", 32'(i_ready), 32'd1);
    begin
      int seen = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (o_valid) seen++;
      end
      chk("midrst_no_leftovers", 32'(seen), 32'd0);
    end
    do_op(8'h7E, 8'h01, 1'b0, 1'b0, lat);
    chk("postrst_latency", 32'(lat), 32'd3);
    chk("postrst_sum", 32'(sum), 32'h7F);
    chk("postrst_overflow", 32'(overflow), 32'd0);

    // STAGES=1, N=16
    @(negedge clk);
    a1 = 16'hFFFF; b1 = 16'h0001; c_in1 = 1'b1; sub1 = 1'b0; i_valid1 = 1'b1;
    #1 chk("s1_i_ready", 32'(i_ready1), 32'd1);
    @(posedge clk); #1;
    i_valid1 = 1'b0;
    chk("s1_o_valid", 32'(o_valid1), 32'd1);
    chk("s1_sum", 32'(sum1), 32'h0001);
    chk("s1_c_out", 32'(c_out1), 32'd1);
    chk("s1_overflow", 32'(overflow1), 32'd0);
    @(posedge clk); #1;
    chk("s1_o_valid_drop", 32'(o_valid1), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adder_pipe_n.md
Name: adder_pipe_n

Overview:
- Pipelined, parametrised N-bit add/subtract unit, the successor to the single-cycle ripple-carry adder.
- Splits the carry chain into STAGES equal chunks with a register after each chunk, which raises Fmax for wide datapaths such as the ALU and the accumulators.
- Uses valid/ready handshakes on both sides.
- Adds a subtract mode, signed-overflow detection and full backpressure.

Parameters:
- N, 32, operand/result width in bits; N % STAGES must be 0.
- STAGES, 4, pipeline depth. Chunk width is CW = N/STAGES. STAGES=1 gives a registered single-cycle adder.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset: synchronous, active-high (single clock domain)
- i_valid  input  1  input operands valid
- i_ready  output  1  unit accepts operands this cycle
- a  input  N  operand A (unsigned or two's complement)
- b  input  N  operand B
- c_in  input  1  carry-in (add) / borrow-in (subtract)
- sub  input  1  0: a+b+c_in; 1: a-b-c_in
- o_valid  output  1  result valid
- o_ready  input  1  downstream accepts result
- sum  output  N  result
- c_out  output  1  carry-out of MSB; for subtract, 1 = no borrow
- overflow  output  1  signed overflow of the operation

Behaviour:
- Operand transform at input: b_eff = sub ? ~b : b; cin_eff = sub ? ~c_in : c_in. Result = a + b_eff + cin_eff, modulo 2^N.
- Stage k (0..STAGES-1):
  - Adds chunk k of a and b_eff plus the carry registered from stage k-1 (cin_eff for stage 0).
  - Registers the CW-bit partial sum and the chunk carry-out.
  - Carries forward the not-yet-consumed upper chunks of a and b_eff, the completed lower sum chunks, and a valid bit.
- Stage STAGES-1 also registers:
  - c_out = carry out of bit N-1.
  - overflow = carry into bit N-1 XOR carry out of bit N-1.
- Latency: a transfer accepted at edge t (i_valid & i_ready) presents o_valid=1 with its result after edge t+STAGES-1, i.e. STAGES cycles later, when there is no stall.
- Throughput: one operation per cycle when o_ready stays high.
- Flow control uses a global enable: en = ~o_valid | o_ready. i_ready = en, purely combinational from o_valid and o_ready.
- When en=0, every stage register, including valid bits, holds. sum, c_out and overflow stay stable while o_valid & ~o_ready.
- When en=1, every stage shifts one position. Stage 0 loads valid = i_valid; its data is don't-care when i_valid=0, but valid must be 0.
- Bubbles propagate as valid=0 stages and are not collapsed.
- Handshake rules:
  - Data is transferred only on i_valid & i_ready (input side) or o_valid & o_ready (output side).
  - A source must not drop i_valid or change operands until a transfer occurs.
  - The unit never drops o_valid or changes outputs until a transfer occurs.
- Simultaneous output accept and input accept in the same cycle is legal and loses no data.
- Reset, including mid-operation: at the first rising edge with rst=1, all in-flight operations are discarded and every register clears.
  - Outputs read o_valid=0, sum=0, c_out=0, overflow=0.
  - i_ready reads 1 during and after reset.
  - The i_valid/o_ready inputs are ignored during reset.
- Boundaries:
  - Carry out of chunk k must reach chunk k+1 with exactly one cycle of skew.
  - Wrap-around is modulo 2^N with no sticky flags.
  - STAGES=1 must elaborate with no zero-width vectors.

Optional Feature:
- Macro: ADDER_PIPE_SATURATE_EN.
- When defined: if overflow=1 in the final stage, sum is clamped to the signed extreme.
  - 0x7FF..F when the true result is positive (a[N-1]=0).
  - 0x800..0 when negative (a[N-1]=1).
  - c_out and overflow still report raw values. Latency is unchanged.
- When undefined: sum is always the wrapped raw result, with no extra logic.

Test Plan:
- N=8, STAGES=4, o_ready=1. Inputs a=0xFF, b=0x01, c_in=0, sub=0, accepted at cycle 0 -> at cycle 4: o_valid=1, sum=0x00, c_out=1, overflow=0.
- Subtract: a=0x05, b=0x07, c_in=0, sub=1 -> sum=0xFE, c_out=0 (borrow), overflow=0. Also a=0x80, b=0x01, sub=1 -> sum=0x7F, overflow=1.
- Overflow/saturate: a=0x7F, b=0x01, sub=0 -> overflow=1.
  - Macro undefined: sum=0x80.
  - Macro defined: sum=0x7F. Also a=0x80, b=0xFF -> 0x80 with overflow=1.
- Throughput and backpressure: stream 10 random ops with i_valid=1, with o_ready=0 for cycles 6-8.
  - i_ready=0 during the stall.
  - Held result is stable across the stall.
  - All 10 results arrive in order and match a reference model; no drops or duplicates.
- Reset mid-operation: 3 ops in flight, assert rst for 1 cycle -> next cycle o_valid=0, sum=0, i_ready=1; a new op then emerges exactly STAGES cycles after acceptance.
- STAGES=1, N=16: a=0xFFFF, b=0x0001, c_in=1 -> sum=0x0001, c_out=1, with 1-cycle latency.
